// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer for a simple in-order core. Fetches one
//   instruction at a time (FETCH), holds it while it executes (EXEC), and
//   resolves branches, JAL and JALR into the next PC. When a byte-addressed
//   redirect target is not 4-byte aligned, it traps (TRAP) until reset.
//
// Parameters
//   PC_W      : program-counter width, 8..32
//   RESET_VEC : PC value loaded on reset
//   WORD_ADDR : 0 = byte addressing (step 4), 1 = word addressing (step 1)
//
// Ports
//   clk, rst_n            : clock (rising edge), async active-low reset
//   fetch_req/fetch_addr  : fetch request and address (= pc)
//   fetch_ack/fetch_instr : fetch completion and returned instruction
//   instr, instr_valid    : latched instruction, high while in EXEC
//   stall                 : holds EXEC
//   br_op, jalr           : branch/jump selection (jalr overrides br_op)
//   rs1_val, rs2_val, imm : compare operands, JALR base, offset
//   pc, link_addr         : current PC and pc + step
//   taken, misalign       : last EXEC redirected, sticky trap flag
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              WORD_ADDR = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            fetch_req,
  output logic [PC_W-1:0] fetch_addr,
  input  logic            fetch_ack,
  input  logic [31:0]     fetch_instr,
  output logic [31:0]     instr,
  output logic            instr_valid,
  input  logic            stall,
  input  logic [2:0]      br_op,
  input  logic            jalr,
  input  logic [31:0]     rs1_val,
  input  logic [31:0]     rs2_val,
  input  logic [31:0]     imm,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] link_addr,
  output logic            taken,
  output logic            misalign
);

  localparam logic [PC_W-1:0] STEP = (WORD_ADDR != 0) ? PC_W'(1) : PC_W'(4);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_TRAP  = 2'd2
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_taken;
  logic            r_misalign;

  state_t          w_state_next;
  logic [PC_W-1:0] w_pc_next;
  logic [31:0]     w_instr_next;
  logic            w_taken_next;
  logic            w_misalign_next;

  logic            w_cond;
  logic            w_redirect;
  logic [31:0]     w_jalr_sum;
  logic [PC_W-1:0] w_target;
  logic            w_bad_target;

  assign pc         = r_pc;
  assign fetch_addr = r_pc;
  assign link_addr  = r_pc + STEP;   // wraps naturally modulo 2^PC_W
  assign instr      = r_instr;
  assign taken      = r_taken;
  assign misalign   = r_misalign;

  // Branch condition decode
  always_comb begin
    w_cond = 1'b0;
    case (br_op)
      3'b001:  w_cond = (rs1_val == rs2_val);
      3'b010:  w_cond = (rs1_val != rs2_val);
      3'b011:  w_cond = ($signed(rs1_val) <  $signed(rs2_val));
      3'b100:  w_cond = ($signed(rs1_val) >= $signed(rs2_val));
      3'b101:  w_cond = (rs1_val <  rs2_val);
      3'b110:  w_cond = (rs1_val >= rs2_val);
      3'b111:  w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_redirect = jalr | w_cond;
  assign w_jalr_sum = rs1_val + imm;

  // Redirect target; JALR is base-relative, everything else PC-relative.
  always_comb begin
    w_target = r_pc + imm[PC_W-1:0];
    if (jalr) begin
      w_target = w_jalr_sum[PC_W-1:0];
      if (WORD_ADDR == 0) w_target[0] = 1'b0;
    end
  end

  // Only byte-addressed redirects can land off a 4-byte boundary.
  assign w_bad_target = (WORD_ADDR == 0) && w_redirect && (w_target[1:0] != 2'b00);

  // Next-state and output logic
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_instr_next    = r_instr;
    w_taken_next    = r_taken;
    w_misalign_next = r_misalign;
    fetch_req       = 1'b0;
    instr_valid     = 1'b0;
    case (r_state)
      S_FETCH: begin
        // Gated by rst_n so no request is visible while reset is held.
        fetch_req = rst_n;
        if (fetch_ack) begin
          w_instr_next = fetch_instr;
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        // Stall wins over any redirect; the target is evaluated again
        // from the live operands on the cycle stall drops.
        if (!stall) begin
          if (w_bad_target) begin
            w_misalign_next = 1'b1;
            w_taken_next    = 1'b0;
            w_state_next    = S_TRAP;
          end else begin
            w_pc_next    = w_redirect ? w_target : link_addr;
            w_taken_next = w_redirect;
            w_state_next = S_FETCH;
          end
        end
      end
      S_TRAP: begin
        // Parked until reset; pc keeps the faulting instruction address.
      end
      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_VEC;
      r_instr    <= '0;
      r_taken    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_instr    <= w_instr_next;
      r_taken    <= w_taken_next;
      r_misalign <= w_misalign_next;
    end
  end

endmodule
